mem_wb_stage: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its M-stage outputs.
- Drives a req/ack data-memory port and raises a stall to the hazard unit while an access is in flight.
- Registers the MEM/WB pipeline values that feed writeback.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/memwb_reg.sv | 63 ++++++
 rtl/mem_wb_stage.sv | 156 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// =====================================================================
// Module  : mips_pkg
// Brief   : Shared widths, memory-stage state encoding and helpers.
// Revision: 1.0
// =====================================================================
package mips_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_REG_W       = 5;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

    // Word accesses only: any set byte-offset bit is a misalignment.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memwb_reg.sv
`default_nettype none
// =====================================================================
// Module  : memwb_reg
// Brief   : MEM/WB pipeline register; bubble clears control, data holds.
// Revision: 1.0
// =====================================================================
module memwb_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic [DATA_W-1:0] aluout_i,
    input  logic [REG_W-1:0]  writereg_i,
    input  logic              rdata_en_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              regwrite_o,
    output logic              memtoreg_o,
    output logic [DATA_W-1:0] readdata_o,
    output logic [DATA_W-1:0] aluout_o,
    output logic [REG_W-1:0]  writereg_o
);

    logic              regwrite_q;
    logic              memtoreg_q;
    logic [DATA_W-1:0] readdata_q;
    logic [DATA_W-1:0] aluout_q;
    logic [REG_W-1:0]  writereg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            readdata_q <= '0;
            aluout_q   <= '0;
            writereg_q <= '0;
        end else if (bubble_i) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else begin
            regwrite_q <= regwrite_i;
            memtoreg_q <= memtoreg_i;
            aluout_q   <= aluout_i;
            writereg_q <= writereg_i;
            if (rdata_en_i) begin
                readdata_q <= rdata_i;
            end
        end
    end

    assign regwrite_o = regwrite_q;
    assign memtoreg_o = memtoreg_q;
    assign readdata_o = readdata_q;
    assign aluout_o   = aluout_q;
    assign writereg_o = writereg_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// =====================================================================
// Module  : mem_wb_stage
// Brief   : MIPS memory stage: dmem req/ack FSM, StallM, MEM/WB register.
//           Define MEM_TIMEOUT_EN to abort stalled accesses with mem_err.
// Revision: 1.0
// =====================================================================
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int REG_W       = DEF_REG_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegwriteM,
    input  logic              MemtoregM,
    input  logic              MemwriteM,
    input  logic [DATA_W-1:0] ALUoutM,
    input  logic [DATA_W-1:0] WritedataM,
    input  logic [REG_W-1:0]  WriteregM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              StallM,
    output logic              mem_misalign,
    output logic              mem_err,
    output logic              RegwriteW,
    output logic              MemtoregW,
    output logic [DATA_W-1:0] ReaddataW,
    output logic [DATA_W-1:0] ALUoutW,
    output logic [REG_W-1:0]  WriteregW
);

    mem_state_t        state_q;
    logic              req_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              misal_q;

    logic access;
    logic misal;
    logic complete;
    logic timeout;

    assign access   = MemtoregM | MemwriteM;
    assign misal    = access & is_misaligned(ALUoutM[1:0]);
    assign complete = (state_q == REQ) & dmem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Fires in the TIMEOUT_CYC-th REQ cycle; a same-cycle ack takes priority.
    assign timeout = (state_q == REQ) & ~dmem_ack & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign mem_err = err_q;
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    // Gated by rst_n so the hazard unit sees the stall drop with the reset.
    assign StallM = rst_n & (((state_q == IDLE) & access & ~misal) |
                             ((state_q == REQ) & ~dmem_ack & ~timeout));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            misal_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            misal_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (misal) begin
                        misal_q <= 1'b1;
                    end else if (access) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        we_q    <= MemwriteM;
                        addr_q  <= ALUoutM;
                        wdata_q <= WritedataM;
`ifdef MEM_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end else if (timeout) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        err_q   <= 1'b1;
`endif
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        cnt_q   <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign mem_misalign = misal_q;

    memwb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_memwb_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .bubble_i   (StallM),
        .regwrite_i (RegwriteM & ~misal & ~timeout),
        .memtoreg_i (MemtoregM),
        .aluout_i   (ALUoutM),
        .writereg_i (WriteregM),
        .rdata_en_i (complete),
        .rdata_i    (dmem_rdata),
        .regwrite_o (RegwriteW),
        .memtoreg_o (MemtoregW),
        .readdata_o (ReaddataW),
        .aluout_o   (ALUoutW),
        .writereg_o (WriteregW)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// =====================================================================
// Module  : tb_mem_wb_stage
// Brief   : Instruction-level self-checking bench for mem_wb_stage.
// Revision: 1.0
// =====================================================================
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          RegwriteM = 1'b0, MemtoregM = 1'b0, MemwriteM = 1'b0;
    logic [DW-1:0] ALUoutM = '0, WritedataM = '0;
    logic [RW-1:0] WriteregM = '0;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata;
    logic          dmem_ack = 1'b0;
    logic [DW-1:0] dmem_rdata = '0;
    logic          StallM, mem_misalign, mem_err;
    logic          RegwriteW, MemtoregW;
    logic [DW-1:0] ReaddataW, ALUoutW;
    logic [RW-1:0] WriteregW;

    int checks = 0;
    int failures = 0;

    // Model of the last value the writeback stage holds as load data.
    logic [DW-1:0] m_readdata = '0;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_W      (DW),
        .REG_W       (RW),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RegwriteM    (RegwriteM),
        .MemtoregM    (MemtoregM),
        .MemwriteM    (MemwriteM),
        .ALUoutM      (ALUoutM),
        .WritedataM   (WritedataM),
        .WriteregM    (WriteregM),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .StallM       (StallM),
        .mem_misalign (mem_misalign),
        .mem_err      (mem_err),
        .RegwriteW    (RegwriteW),
        .MemtoregW    (MemtoregW),
        .ReaddataW    (ReaddataW),
        .ALUoutW      (ALUoutW),
        .WriteregW    (WriteregW)
    );

    // One instruction through M. Entered and left at a falling edge.
    // An aligned access occupies M for exactly delay+2 cycles.
    task automatic run_instr(input logic rw, input logic mtr, input logic mw,
                             input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                             input logic [RW-1:0] wr, input int delay,
                             input logic [DW-1:0] rdata, input string tag);
        logic acc, mis;
        logic [2*DW+RW+1:0] exp_w;
        acc = mtr | mw;
        mis = acc && (alu[1:0] != 2'b00);
        RegwriteM = rw; MemtoregM = mtr; MemwriteM = mw;
        ALUoutM = alu; WritedataM = wd; WriteregM = wr;
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1;
        checks++;
        if (StallM !== (acc && !mis))
            $display("FAIL %s stall_first: got %0b expected %0b", tag, StallM, acc && !mis);
        if (acc && !mis) begin
            @(posedge clk); #1;
            for (int k = 0; k <= delay; k++) begin
                checks++;
                if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, mw, alu, wd}) begin
                    failures++;
                    $display("FAIL %s req_hold[%0d]: got req=%0b we=%0b addr=%h wdata=%h expected req=1 we=%0b addr=%h wdata=%h",
                             tag, k, dmem_req, dmem_we, dmem_addr, dmem_wdata, mw, alu, wd);
                end
                checks++;
                if ({RegwriteW, MemtoregW} !== 2'b00) begin
                    failures++;
                    $display("FAIL %s bubble[%0d]: got %b expected 00", tag, k, {RegwriteW, MemtoregW});
                end
                @(negedge clk);
                dmem_ack = (k == delay);
                dmem_rdata = (k == delay) ? rdata : $urandom;
                #1;
                checks++;
                if (StallM !== (k != delay)) begin
                    failures++;
                    $display("FAIL %s stall_req[%0d]: got %0b expected %0b", tag, k, StallM, k != delay);
                end
                @(posedge clk); #1;
            end
            m_readdata = rdata;
            dmem_ack = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
        exp_w = {rw & ~mis, mtr, alu, wr, m_readdata};
        checks++;
        if ({RegwriteW, MemtoregW, ALUoutW, WriteregW, ReaddataW} !== exp_w) begin
            failures++;
            $display("FAIL %s wb: got rw=%0b mtr=%0b alu=%h wr=%0d rd=%h expected rw=%0b mtr=%0b alu=%h wr=%0d rd=%h",
                     tag, RegwriteW, MemtoregW, ALUoutW, WriteregW, ReaddataW,
                     rw & ~mis, mtr, alu, wr, m_readdata);
        end
        checks++;
        if ({dmem_req, mem_misalign, mem_err} !== {1'b0, mis, 1'b0}) begin
            failures++;
            $display("FAIL %s flags: got req/misal/err=%b expected %b", tag,
                     {dmem_req, mem_misalign, mem_err}, {1'b0, mis, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, StallM, mem_misalign, mem_err,
             RegwriteW, MemtoregW, ReaddataW, ALUoutW, WriteregW} !== '0) begin
            failures++;
            $display("FAIL reset_state: got req=%0b addr=%h stall=%0b rw=%0b alu=%h expected all zero",
                     dmem_req, dmem_addr, StallM, RegwriteW, ALUoutW);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu();
        run_instr(1'b1, 1'b0, 1'b0, 32'h0000_1234, $urandom, 5'd5, 0, '0, "alu");
    endtask

    task automatic test_load();
        run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0040, $urandom, 5'd9, 0, 32'hDEAD_BEEF, "load");
    endtask

    task automatic test_store();
        run_instr(1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 5'd3, 4, $urandom, "store");
    endtask

    task automatic test_misalign();
        run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0042, $urandom, 5'd7, 0, '0, "misalign");
    endtask

    task automatic test_reset_mid();
        RegwriteM = 1'b1; MemtoregM = 1'b1; MemwriteM = 1'b0;
        ALUoutM = 32'h0000_0100; WriteregM = 5'd4; dmem_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre: got req=%0b expected 1", dmem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req, StallM, RegwriteW, MemtoregW, ALUoutW, WriteregW, ReaddataW} !== '0) begin
            failures++;
            $display("FAIL rst_mid_async: got req=%0b stall=%0b rw=%0b alu=%h expected all zero",
                     dmem_req, StallM, RegwriteW, ALUoutW);
        end
        @(negedge clk);
        RegwriteM = 1'b0; MemtoregM = 1'b0; ALUoutM = '0; WriteregM = '0;
        rst_n = 1'b1;
        m_readdata = '0;
        @(posedge clk); #1;
        checks++;
        if ({dmem_req, StallM, RegwriteW, MemtoregW, ALUoutW, WriteregW, ReaddataW} !== '0) begin
            failures++;
            $display("FAIL rst_mid_after: got req=%0b stall=%0b rw=%0b alu=%h rd=%h expected all zero",
                     dmem_req, StallM, RegwriteW, ALUoutW, ReaddataW);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int kind;
        logic rw, mtr, mw;
        logic [DW-1:0] alu;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            alu = $urandom;
            case (kind)
                0: begin rw = 1'($urandom_range(0, 1)); mtr = 1'b0; mw = 1'b0; end
                1: begin rw = 1'b1; mtr = 1'b1; mw = 1'b0; alu[1:0] = 2'b00; end
                2: begin rw = 1'b0; mtr = 1'b0; mw = 1'b1; alu[1:0] = 2'b00; end
                default: begin
                    mw = 1'($urandom_range(0, 1)); mtr = ~mw; rw = mtr;
                    alu[1:0] = 2'($urandom_range(1, 3));
                end
            endcase
            run_instr(rw, mtr, mw, alu, $urandom, 5'($urandom), $urandom_range(0, 7),
                      $urandom, "b2b");
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        RegwriteM = 1'b1; MemtoregM = 1'b1; MemwriteM = 1'b0;
        ALUoutM = 32'h0000_0200; WriteregM = 5'd6; dmem_ack = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #1;
            checks++;
            if (StallM !== (k != 8)) begin
                failures++;
                $display("FAIL timeout_stall[%0d]: got %0b expected %0b", k, StallM, k != 8);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({dmem_req, mem_err, RegwriteW, ReaddataW} !== {1'b0, 1'b1, 1'b0, m_readdata}) begin
            failures++;
            $display("FAIL timeout_abort: got req=%0b err=%0b rw=%0b rd=%h expected req=0 err=1 rw=0 rd=%h",
                     dmem_req, mem_err, RegwriteW, ReaddataW, m_readdata);
        end
        @(negedge clk);
        run_instr(1'b0, 1'b0, 1'b0, $urandom, $urandom, 5'd0, 0, '0, "after_timeout");
        run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0300, $urandom, 5'd8, 7, 32'h1357_9BDF, "ack_at_limit");
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_alu();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
